// File: rtl/ro_sac_pkg.sv
// Shared types and width helpers for the read-only set-associative cache.
package ro_sac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Byte-offset bits within one line.
    function automatic int ob_w(input int lw);
        return $clog2(lw / 8);
    endfunction

    function automatic int idx_w(input int nl);
        return $clog2(nl);
    endfunction

    function automatic int tag_w(input int aw, input int lw, input int nl);
        return aw - ob_w(lw) - idx_w(nl);
    endfunction

    // Word-select bits (32-bit words per line).
    function automatic int ws_w(input int lw);
        return $clog2(lw / 32);
    endfunction

endpackage

// File: rtl/ro_sac_way.sv
// One cache way: per-set valid bit, tag and line store with combinational
// lookup, tag compare, word select and a single fill write port.
module ro_sac_way
    import ro_sac_pkg::*;
#(
    parameter int LW = 512,
    parameter int NL = 64,
    parameter int AW = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [idx_w(NL)-1:0]          rd_idx,
    input  logic [tag_w(AW,LW,NL)-1:0]    rd_tag,
    input  logic [ws_w(LW)-1:0]           word_sel,
    output logic                          match,
    output logic                          valid,
    output logic [31:0]                   word,
    input  logic                          wr_en,
    input  logic [idx_w(NL)-1:0]          wr_idx,
    input  logic [tag_w(AW,LW,NL)-1:0]    wr_tag,
    input  logic [LW-1:0]                 wr_data
);

    localparam int TW = tag_w(AW, LW, NL);

    logic [NL-1:0] valid_reg;
    logic [TW-1:0] tag_mem  [NL];
    logic [LW-1:0] data_mem [NL];
    logic [LW-1:0] rd_line;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    // Tag and data stores carry no reset; the valid bit guards them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign valid   = valid_reg[rd_idx];
    assign match   = valid && (tag_mem[rd_idx] == rd_tag);
    assign rd_line = data_mem[rd_idx];
    assign word    = match ? rd_line[{word_sel, 5'b0} +: 32] : 32'd0;

endmodule

// File: rtl/ro_sac.sv
// Read-only WAYS-way set-associative cache, one line fill per miss.
// Optional hit/miss counters are built when RO_SAC_STATS_EN is defined.
module ro_sac
    import ro_sac_pkg::*;
#(
    parameter int LW   = 512,
    parameter int NL   = 64,
    parameter int WAYS = 2,
    parameter int AW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_hit,
    output logic [31:0]   cpu_data,
    output logic          m_start,
    output logic [AW-1:0] m_addr,
    input  logic [LW-1:0] m_data,
    input  logic          m_done,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
);

    localparam int OB = ob_w(LW);
    localparam int IW = idx_w(NL);
    localparam int TW = tag_w(AW, LW, NL);
    localparam int RW = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t          state_reg, state_next;
    logic [AW-1:0]   m_addr_reg;
    logic [IW-1:0]   look_idx, fill_idx;
    logic [TW-1:0]   cpu_tag, fill_tag;
    logic [WAYS-1:0] match_vec, valid_vec, wr_vec;
    logic [31:0]     word_vec [WAYS];
    logic [31:0]     hit_word;
    logic [RW-1:0]   victim;
    logic            any_match, miss_start, fill;
    logic            unused_bits;

    assign fill_idx   = m_addr_reg[OB+IW-1:OB];
    assign fill_tag   = m_addr_reg[AW-1:OB+IW];
    assign cpu_tag    = cpu_addr[AW-1:OB+IW];
    // Outside IDLE the ways look at the fill set so victim choice sees its valid bits.
    assign look_idx   = (state_reg == IDLE) ? cpu_addr[OB+IW-1:OB] : fill_idx;
    assign fill       = (state_reg != IDLE) && m_done;
    assign any_match  = |match_vec;
    assign miss_start = (state_reg == IDLE) && cpu_rd && !any_match;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            ro_sac_way #(.LW(LW), .NL(NL), .AW(AW)) u_way (
                .clk      (clk),
                .rst_n    (rst_n),
                .rd_idx   (look_idx),
                .rd_tag   (cpu_tag),
                .word_sel (cpu_addr[OB-1:2]),
                .match    (match_vec[gi]),
                .valid    (valid_vec[gi]),
                .word     (word_vec[gi]),
                .wr_en    (wr_vec[gi]),
                .wr_idx   (fill_idx),
                .wr_tag   (fill_tag),
                .wr_data  (m_data)
            );
            assign wr_vec[gi] = fill && (victim == RW'(gi));
        end

        if (WAYS > 1) begin : g_rr
            logic [RW-1:0] rr_reg [NL];
            logic [RW-1:0] rr_cur;

            assign rr_cur = rr_reg[fill_idx];

            // Lowest invalid way wins; otherwise the round-robin pointer.
            always_comb begin
                victim = rr_cur;
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (!valid_vec[w]) victim = RW'(w);
                end
            end

            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    for (int s = 0; s < NL; s++) rr_reg[s] <= '0;
                end else if (fill && (&valid_vec)) begin
                    rr_reg[fill_idx] <= rr_cur + 1'b1;
                end
            end
        end else begin : g_dm
            assign victim = '0;
        end
    endgenerate

    always_comb begin
        hit_word = 32'd0;
        for (int w = 0; w < WAYS; w++) hit_word = hit_word | word_vec[w];
    end

    assign cpu_hit     = cpu_rd && (state_reg == IDLE) && any_match;
    assign cpu_data    = cpu_hit ? hit_word : 32'd0;
    assign m_addr      = m_addr_reg;
    assign unused_bits = ^{cpu_addr[1:0], valid_vec};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg  <= IDLE;
            m_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (miss_start) m_addr_reg <= {cpu_addr[AW-1:OB], {OB{1'b0}}};
        end
    end

    always_comb begin
        state_next = state_reg;
        m_start    = 1'b0;
        case (state_reg)
            IDLE: if (miss_start) state_next = MISS;
            MISS: begin
                m_start    = 1'b1;
                state_next = m_done ? IDLE : WAIT;
            end
            WAIT: if (m_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef RO_SAC_STATS_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hit_cnt_reg  <= 32'd0;
            miss_cnt_reg <= 32'd0;
        end else begin
            if (cpu_hit && (hit_cnt_reg != 32'hFFFF_FFFF))
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (miss_start && (miss_cnt_reg != 32'hFFFF_FFFF))
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ro_sac.sv
// Scoreboard bench for ro_sac (LW=512, NL=64, WAYS=2): expected words are
// queued when a read is driven and compared when the cache reports a hit.
module tb_ro_sac;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cpu_rd = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic         cpu_hit;
    logic [31:0]  cpu_data;
    logic         m_start;
    logic [31:0]  m_addr;
    logic [511:0] m_data = '0;
    logic         m_done = 1'b0;
    logic [31:0]  hit_cnt, miss_cnt;

    int checks = 0;
    int failures = 0;
    int exp_hit_cnt = 0;
    int exp_miss_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ro_sac #(.LW(512), .NL(64), .WAYS(2), .AW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_rd   (cpu_rd),
        .cpu_addr (cpu_addr),
        .cpu_hit  (cpu_hit),
        .cpu_data (cpu_data),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_done   (m_done),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory contents: word w of line la.
    function automatic logic [31:0] word_of(input logic [31:0] la, input int w);
        return la ^ (32'h1111_1111 * (w + 1));
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] la);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[32*w +: 32] = word_of(la, w);
        return l;
    endfunction

    task automatic check_counters();
`ifdef RO_SAC_STATS_EN
        check_eq("hit_cnt", hit_cnt, exp_hit_cnt);
        check_eq("miss_cnt", miss_cnt, exp_miss_cnt);
`else
        check_eq("hit_cnt_off", hit_cnt, 32'd0);
        check_eq("miss_cnt_off", miss_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cpu_rd = 1'b0;
        m_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_hit_cnt  = 0;
        exp_miss_cnt = 0;
    endtask

    // One read: delay = WAIT cycles between m_start and m_done, hold = hit cycles.
    task automatic do_read(input logic [31:0] addr, input bit exp_miss,
                           input int delay, input int hold);
        logic [31:0] la;
        logic [31:0] exp_word;
        la = {addr[31:6], 6'b0};
        @(posedge clk); #1;
        cpu_rd   = 1'b1;
        cpu_addr = addr;
        exp_q.push_back(word_of(la, int'(addr[5:2])));
        @(negedge clk);
        check_eq("hit_detect", {31'd0, cpu_hit}, {31'd0, !exp_miss});
        if (exp_miss) begin
            exp_miss_cnt++;
            @(negedge clk);
            check_eq("m_start", {31'd0, m_start}, 32'd1);
            check_eq("m_addr", m_addr, la);
            check_eq("no_hit_in_miss", {31'd0, cpu_hit}, 32'd0);
            check_eq("data_zero_in_miss", cpu_data, 32'd0);
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                check_eq("m_start_pulse", {31'd0, m_start}, 32'd0);
                check_eq("m_addr_hold", m_addr, la);
            end
            m_data = line_of(la);
            m_done = 1'b1;
            @(posedge clk); #1;
            m_done = 1'b0;
            m_data = '0;
            @(negedge clk);
        end
        exp_word = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            if (h > 0) @(negedge clk);
            check_eq("hit", {31'd0, cpu_hit}, 32'd1);
            check_eq("data", cpu_data, exp_word);
            exp_hit_cnt++;
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        @(negedge clk);
        check_counters();
        $display("read addr=%h miss=%0d data=%h", addr, exp_miss, exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check_eq("rst_hit", {31'd0, cpu_hit}, 32'd0);
        check_eq("rst_data", cpu_data, 32'd0);
        check_eq("rst_m_start", {31'd0, m_start}, 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_counters();

        // Cold miss, word select, second set
        do_read(32'h0000_0000, 1'b1, 2, 1);
        do_read(32'h0000_0004, 1'b0, 0, 1);
        do_read(32'hABCD_EF88, 1'b1, 1, 1);
        do_read(32'hABCD_EF88, 1'b0, 0, 1);

        // Replacement in set 0
        do_read(32'h0000_1000, 1'b1, 1, 1);   // invalid way1
        do_read(32'h0000_2000, 1'b1, 1, 1);   // evicts way0 (0x0), rr->1
        do_read(32'h0000_1000, 1'b0, 0, 1);
        do_read(32'h0000_0000, 1'b1, 1, 1);   // evicts way1 (0x1000), rr->0
        do_read(32'h0000_2000, 1'b0, 0, 1);
        do_read(32'h0000_1000, 1'b1, 1, 1);   // evicts way0 (0x2000)
        do_read(32'h0000_0008, 1'b0, 0, 1);

        // m_done coincident with m_start
        do_read(32'h0000_5044, 1'b1, 0, 1);
        do_read(32'h0000_5040, 1'b0, 0, 1);

        // Reset during WAIT aborts the fill
        @(posedge clk); #1;
        cpu_rd   = 1'b1;
        cpu_addr = 32'h0000_8000;
        @(negedge clk);
        check_eq("abort_hit_detect", {31'd0, cpu_hit}, 32'd0);
        @(negedge clk);
        check_eq("abort_m_start", {31'd0, m_start}, 32'd1);
        @(negedge clk);
        do_reset();
        @(negedge clk);
        m_data = line_of(32'h0000_8000);
        m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
        m_data = '0;
        @(negedge clk);
        check_eq("abort_m_addr", m_addr, 32'd0);
        check_eq("abort_m_start_idle", {31'd0, m_start}, 32'd0);
        check_counters();
        do_read(32'h0000_8000, 1'b1, 1, 1);
        do_read(32'h0000_0000, 1'b1, 2, 1);

        // Third miss plus a held hit: 3 misses, 5 hit cycles since reset
        do_read(32'h0000_9000, 1'b1, 1, 1);
        do_read(32'h0000_9004, 1'b0, 0, 2);
`ifdef RO_SAC_STATS_EN
        check_eq("stats_miss", miss_cnt, 32'd3);
        check_eq("stats_hit", hit_cnt, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
